// File: rtl/fetch_load_sequencer.sv
// rtl/fetch_load_sequencer.sv - multi-cycle FETCH/LOAD memory-read sequencer for the ALU system
module fetch_load_sequencer #(
  parameter logic [1:0] PC_SEL_D     = 2'b00,
  parameter logic [1:0] AR_SEL_D     = 2'b10,
  parameter bit         CLR_DR_FIRST = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_op_i,
  input  logic [1:0] cmd_len_i,
  input  logic [1:0] cmd_dest_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       mem_cs_o,
  output logic       mem_wr_o,
  output logic [1:0] arf_outdsel_o,
  output logic [2:0] arf_regsel_o,
  output logic [1:0] arf_funsel_o,
  output logic       ir_write_o,
  output logic       ir_lh_o,
  output logic       dr_e_o,
  output logic [1:0] dr_funsel_o,
  output logic [1:0] mux_asel_o,
  output logic [3:0] rf_regsel_o,
  output logic [3:0] rf_scrsel_o,
  output logic [2:0] rf_funsel_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    F_LO   = 3'd1,
    F_HI   = 3'd2,
    L_CLR  = 3'd3,
    L_BYTE = 3'd4,
    L_WB   = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] count_q, count_d;
  logic [1:0] len_q, len_d;
  logic [1:0] dest_q, dest_d;

  logic       cmd_ready_q, busy_q, done_q, mem_cs_q;
  logic [1:0] arf_outdsel_q, arf_funsel_q, dr_funsel_q, mux_asel_q;
  logic [2:0] arf_regsel_q, rf_funsel_q;
  logic       ir_write_q, ir_lh_q, dr_e_q;
  logic [3:0] rf_regsel_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    dest_d  = dest_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          len_d   = cmd_len_i;
          dest_d  = cmd_dest_i;
          count_d = 2'd0;
          if (!cmd_op_i)         state_d = F_LO;
          else if (CLR_DR_FIRST) state_d = L_CLR;
          else                   state_d = L_BYTE;
        end
      end
      F_LO:  state_d = F_HI;
      F_HI:  state_d = DONE;
      L_CLR: state_d = L_BYTE;
      L_BYTE: begin
        if (count_q == len_q) state_d = L_WB;
        else                  count_d = count_q + 2'd1;
      end
      L_WB:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= 2'd0;
      len_q   <= 2'd0;
      dest_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      dest_q  <= dest_d;
    end

    cmd_ready_q   <= 1'b0;
    busy_q        <= 1'b1;
    done_q        <= 1'b0;
    mem_cs_q      <= 1'b1;
    arf_outdsel_q <= 2'b00;
    arf_regsel_q  <= 3'b000;
    arf_funsel_q  <= 2'b00;
    ir_write_q    <= 1'b0;
    ir_lh_q       <= 1'b0;
    dr_e_q        <= 1'b0;
    dr_funsel_q   <= 2'b00;
    mux_asel_q    <= 2'b00;
    rf_regsel_q   <= 4'b0000;
    rf_funsel_q   <= 3'b000;

    if (rst_i) begin
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_d)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        F_LO, F_HI: begin
          mem_cs_q      <= 1'b0;
          arf_outdsel_q <= PC_SEL_D;
          ir_write_q    <= 1'b1;
          ir_lh_q       <= (state_d == F_HI);
          arf_regsel_q  <= 3'b100;
          arf_funsel_q  <= 2'b01;
        end
        L_CLR: begin
          dr_e_q      <= 1'b1;
          dr_funsel_q <= 2'b00;
        end
        L_BYTE: begin
          mem_cs_q      <= 1'b0;
          arf_outdsel_q <= AR_SEL_D;
          dr_e_q        <= 1'b1;
          dr_funsel_q   <= 2'b10;
          arf_regsel_q  <= 3'b001;
          arf_funsel_q  <= 2'b01;
        end
        L_WB: begin
          mux_asel_q  <= 2'b10;
          rf_funsel_q <= 3'b010;
          rf_regsel_q <= 4'b1000 >> dest_d;
        end
        DONE:    done_q <= 1'b1;
        default: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign mem_cs_o      = mem_cs_q;
  assign mem_wr_o      = 1'b0;
  assign arf_outdsel_o = arf_outdsel_q;
  assign arf_regsel_o  = arf_regsel_q;
  assign arf_funsel_o  = arf_funsel_q;
  assign ir_write_o    = ir_write_q;
  assign ir_lh_o       = ir_lh_q;
  assign dr_e_o        = dr_e_q;
  assign dr_funsel_o   = dr_funsel_q;
  assign mux_asel_o    = mux_asel_q;
  assign rf_regsel_o   = rf_regsel_q;
  assign rf_scrsel_o   = 4'b0000;
  assign rf_funsel_o   = rf_funsel_q;

endmodule

// File: tb/tb_fetch_load_sequencer.sv
// tb/tb_fetch_load_sequencer.sv - directed bench with a small ALU-system model around the sequencer
module tb_fetch_load_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_op;
  logic [1:0] cmd_len, cmd_dest;
  logic       cmd_ready, busy, done, mem_cs, mem_wr;
  logic [1:0] arf_outdsel, arf_funsel, dr_funsel, mux_asel;
  logic [2:0] arf_regsel, rf_funsel;
  logic       ir_write, ir_lh, dr_e;
  logic [3:0] rf_regsel, rf_scrsel;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_load_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_len_i(cmd_len), .cmd_dest_i(cmd_dest),
    .busy_o(busy), .done_o(done), .mem_cs_o(mem_cs), .mem_wr_o(mem_wr),
    .arf_outdsel_o(arf_outdsel), .arf_regsel_o(arf_regsel), .arf_funsel_o(arf_funsel),
    .ir_write_o(ir_write), .ir_lh_o(ir_lh), .dr_e_o(dr_e), .dr_funsel_o(dr_funsel),
    .mux_asel_o(mux_asel), .rf_regsel_o(rf_regsel), .rf_scrsel_o(rf_scrsel),
    .rf_funsel_o(rf_funsel)
  );

  // Datapath model: memory, PC/AR, IR, DR and R1..R4 reacting to the control outputs.
  logic [7:0]  mem [0:65535];
  logic [15:0] pc, ar, ir;
  logic [31:0] dr;
  logic [31:0] r [0:3];
  logic [15:0] rd_log [0:15];
  logic [7:0]  rd_cnt;
  logic        ld_en, ld_clr_r;
  logic [15:0] ld_pc, ld_ar;
  logic [31:0] ld_dr;
  logic [15:0] addr;
  logic [7:0]  rbyte;

  assign addr  = (arf_outdsel == 2'b00) ? pc : (arf_outdsel == 2'b10) ? ar : 16'h0000;
  assign rbyte = mem[addr];

  always @(posedge clk) begin
    if (ld_en) begin
      pc <= ld_pc;
      ar <= ld_ar;
      dr <= ld_dr;
      if (ld_clr_r) begin
        for (int i = 0; i < 4; i++) r[i] <= 32'h0;
        rd_cnt <= 8'd0;
      end
    end else begin
      if (ir_write && !mem_cs) begin
        if (ir_lh) ir[15:8] <= rbyte;
        else       ir[7:0]  <= rbyte;
      end
      if (dr_e && dr_funsel == 2'b00) dr <= 32'h0;
      if (dr_e && dr_funsel == 2'b10 && !mem_cs) begin
        dr <= {dr[23:0], rbyte};
        rd_log[rd_cnt[3:0]] <= addr;
        rd_cnt <= rd_cnt + 8'd1;
      end
      if (arf_funsel == 2'b01) begin
        if (arf_regsel[2]) pc <= pc + 16'd1;
        if (arf_regsel[0]) ar <= ar + 16'd1;
      end
      if (rf_funsel == 3'b010 && mux_asel == 2'b10)
        for (int i = 0; i < 4; i++) if (rf_regsel[3-i]) r[i] <= dr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] p, input logic [15:0] a, input logic [31:0] d,
                         input logic clr_r);
    @(negedge clk);
    ld_pc = p; ld_ar = a; ld_dr = d; ld_clr_r = clr_r; ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0; ld_clr_r = 1'b0;
  endtask

  logic       cs_log  [0:31];
  logic [3:0] rfs_log [0:31];
  logic [2:0] arf_log [0:31];
  logic       lh_log  [0:31];

  // Issues one command; lat is the cycle index (1 = first cycle after acceptance) of Done, 0 on timeout.
  task automatic run_cmd(input logic op, input logic [1:0] len, input logic [1:0] dest,
                         output int lat);
    lat = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_dest = dest;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_len = 2'd0; cmd_dest = 2'd0;
    for (int k = 1; k < 20; k++) begin
      cs_log[k] = mem_cs; rfs_log[k] = rf_regsel; arf_log[k] = arf_regsel; lh_log[k] = ir_lh;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  int lat;
  int ndone;
  logic [7:0]  cnt0;
  logic [31:0] r_snap [0:3];
  logic        saw_done;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_len = 2'd0; cmd_dest = 2'd0;
    ld_en = 1'b0; ld_clr_r = 1'b0; ld_pc = 16'h0; ld_ar = 16'h0; ld_dr = 32'h0;
    ir = 16'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1. idle outputs after reset
    check("idle_ready", {31'd0, cmd_ready}, 32'd1);
    check("idle_cs",    {31'd0, mem_cs}, 32'd1);
    check("idle_busy_done", {30'd0, busy, done}, 32'd0);
    check("idle_enables", {17'd0, mem_wr, ir_write, dr_e, arf_regsel, rf_regsel, rf_scrsel},
          32'd0);
    check("idle_sels", {19'd0, arf_outdsel, arf_funsel, dr_funsel, mux_asel, rf_funsel}, 32'd0);

    // 2. FETCH from PC=0x0010
    mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
    preload(16'h0010, 16'h0000, 32'h0, 1'b1);
    run_cmd(1'b0, 2'd3, 2'd2, lat);
    check("fetch_latency", lat, 3);
    check("fetch_ir", {16'd0, ir}, 32'h1234);
    check("fetch_pc", {16'd0, pc}, 32'h0012);
    check("fetch_lo_ctl", {27'd0, cs_log[1], arf_log[1], lh_log[1]}, {27'd0, 1'b0, 3'b100, 1'b0});
    check("fetch_hi_lh", {31'd0, lh_log[2]}, 32'd1);

    // 3. LOAD Len=3 to R3 from AR=0x0020
    mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22; mem[16'h0022] = 8'h33; mem[16'h0023] = 8'h44;
    preload(16'h0012, 16'h0020, 32'hFFFF_FFFF, 1'b0);
    run_cmd(1'b1, 2'd3, 2'd2, lat);
    check("load4_latency", lat, 7);
    check("load4_r3", r[2], 32'h1122_3344);
    check("load4_ar", {16'd0, ar}, 32'h0024);
    check("load4_wb_sel", {28'd0, rfs_log[6]}, 32'b0010);
    check("load4_others", r[0] | r[1] | r[3], 32'h0);

    // 4. LOAD Len=0 to R1, DR preloaded: clear cycle wipes upper bytes
    mem[16'h0040] = 8'h5A;
    preload(16'h0012, 16'h0040, 32'hAABB_CCDD, 1'b0);
    cnt0 = rd_cnt;
    run_cmd(1'b1, 2'd0, 2'd0, lat);
    check("load1_latency", lat, 4);
    check("load1_r1", r[0], 32'h0000_005A);
    check("load1_ar", {16'd0, ar}, 32'h0041);
    check("load1_reads", {24'd0, rd_cnt - cnt0}, 32'd1);

    // 5. LOAD Len=1 across the AR wrap
    mem[16'hFFFF] = 8'hC3; mem[16'h0000] = 8'h7E;
    preload(16'h0012, 16'hFFFF, 32'h1234_5678, 1'b0);
    cnt0 = rd_cnt;
    run_cmd(1'b1, 2'd1, 2'd1, lat);
    check("wrap_latency", lat, 5);
    check("wrap_r2", r[1], 32'h0000_C37E);
    check("wrap_ar", {16'd0, ar}, 32'h0001);
    check("wrap_addr0", {16'd0, rd_log[cnt0[3:0]]}, 32'h0000_FFFF);
    check("wrap_addr1", {16'd0, rd_log[cnt0[3:0] + 4'd1]}, 32'h0000_0000);

    // 6a. Cmd_Valid held high through FETCH: one Done, re-accepted in the IDLE cycle after DONE
    mem[16'h0050] = 8'hEF; mem[16'h0051] = 8'hBE; mem[16'h0052] = 8'hAD; mem[16'h0053] = 8'hDE;
    preload(16'h0050, 16'h0000, 32'h0, 1'b0);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_len = 2'd0; cmd_dest = 2'd0;
    @(negedge clk);
    ndone = 0;
    for (int k = 1; k <= 4; k++) begin
      if (done) ndone++;
      if (k == 4) check("held_ready_after_done", {31'd0, cmd_ready}, 32'd1);
      if (k == 3) check("held_first_ir", {16'd0, ir}, 32'h0000_BEEF);
      @(negedge clk);
    end
    check("held_one_done", ndone, 1);
    cmd_valid = 1'b0;
    ndone = 0;
    for (int k = 5; k <= 8; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("held_second_done", ndone, 1);
    check("held_second_ir", {16'd0, ir}, 32'h0000_DEAD);
    check("held_pc", {16'd0, pc}, 32'h0054);

    // 6b. Reset while in L_BYTE
    mem[16'h0060] = 8'h99; mem[16'h0061] = 8'h88;
    preload(16'h0054, 16'h0060, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) r_snap[i] = r[i];
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = 2'd3; cmd_dest = 2'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_in_lbyte", {29'd0, dr_e, dr_funsel}, {29'd0, 1'b1, 2'b10});
    rst = 1'b1;
    @(negedge clk);
    check("rst_idle_ready", {30'd0, cmd_ready, busy}, 32'b10);
    check("rst_idle_ctl", {26'd0, mem_cs, dr_e, arf_regsel, done}, {26'd0, 1'b1, 5'd0});
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done || rf_regsel != 4'd0) saw_done = 1'b1;
      @(negedge clk);
    end
    check("rst_no_writeback", {31'd0, saw_done}, 32'd0);
    check("rst_r_unchanged", {28'd0, r[0] == r_snap[0], r[1] == r_snap[1],
                              r[2] == r_snap[2], r[3] == r_snap[3]}, 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
